// File: rtl/retire_trace_buffer_if.sv
// Reader-side handshake for the retirement trace buffer: one record per valid/ready transfer.
interface retire_trace_buffer_if #(
   parameter int unsigned SEQ_W = 16
);
   logic             valid;
   logic             ready;
   logic [31:0]      pc;
   logic [31:0]      ir;
   logic [SEQ_W-1:0] seq;

   modport master (output valid, output pc, output ir, output seq, input ready);
   modport slave  (input valid, input pc, input ir, input seq, output ready);
endinterface

// File: rtl/retire_trace_buffer.sv
// Captures retired MEM/WB instructions into a show-ahead FIFO drained over a valid/ready port.
// Each capture consumes a sequence number whether stored or dropped, so gaps reveal drops.
module retire_trace_buffer #(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned DROP_NOPS = 1,
   parameter int unsigned SEQ_W     = 16,
   parameter int unsigned CNT_W     = 16,
   localparam int unsigned AW       = $clog2(DEPTH),
   localparam int unsigned LW       = AW + 1
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  enable_i,
   input  logic                  clear_i,
   input  logic                  wb_valid_i,
   input  logic [31:0]           wb_pc_plus4_i,
   input  logic [31:0]           wb_instruction_i,
   retire_trace_buffer_if.master trace,
   output logic                  overflow_o,
   output logic [CNT_W-1:0]      drop_count_o,
   output logic [LW-1:0]         level_o
);

   logic [31:0]      pc_mem  [DEPTH];
   logic [31:0]      ir_mem  [DEPTH];
   logic [SEQ_W-1:0] seq_mem [DEPTH];

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic [SEQ_W-1:0] seq_q, seq_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic             overflow_q, overflow_d;

   logic is_nop, capture, full, pop, push, drop;

   always_comb begin
      is_nop     = (DROP_NOPS != 0) && (wb_instruction_i == 32'h0);
      capture    = enable_i & wb_valid_i & ~is_nop;
      full       = (level_q == LW'(DEPTH));
      pop        = (level_q != '0) & trace.ready;
      // A pop on the same edge frees the slot, so a full FIFO still accepts the event.
      push       = capture & (~full | pop);
      drop       = capture & full & ~pop;

      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      seq_d      = seq_q;
      drop_d     = drop_q;
      overflow_d = overflow_q;

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      level_d = level_q + 1'b1;
      else if (pop && !push) level_d = level_q - 1'b1;
      if (capture) seq_d = seq_q + 1'b1;
      if (drop) begin
         overflow_d = 1'b1;
         if (drop_q != '1) drop_d = drop_q + 1'b1;
      end

      if (clear_i) begin
         push       = 1'b0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         level_d    = '0;
         seq_d      = '0;
         drop_d     = '0;
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         seq_q      <= '0;
         drop_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         seq_q      <= seq_d;
         drop_q     <= drop_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is not reset; head outputs are masked to zero while empty.
   always_ff @(posedge clk_i) begin
      if (push && !reset_i) begin
         pc_mem[wr_ptr_q]  <= wb_pc_plus4_i - 32'd4;
         ir_mem[wr_ptr_q]  <= wb_instruction_i;
         seq_mem[wr_ptr_q] <= seq_q;
      end
   end

   assign trace.valid  = (level_q != '0);
   assign trace.pc     = trace.valid ? pc_mem[rd_ptr_q]  : '0;
   assign trace.ir     = trace.valid ? ir_mem[rd_ptr_q]  : '0;
   assign trace.seq    = trace.valid ? seq_mem[rd_ptr_q] : '0;
   assign overflow_o   = overflow_q;
   assign drop_count_o = drop_q;
   assign level_o      = level_q;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Scoreboard bench: stimulus queues expected records, per-DUT monitors compare on each pop.
module tb_retire_trace_buffer;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ir;
      logic [31:0] seq;
   } rec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_valid;
   logic [31:0] pc4, ir;
   logic        en_a, en_b, en_c;
   logic        clear_a, clear_b, clear_c;
   logic        ovf_a, ovf_b, ovf_c;
   logic [15:0] drop_a, drop_b, drop_c;
   logic [4:0]  lvl_a, lvl_b, lvl_c;

   int n_pass  = 0;
   int n_total = 0;
   rec_t qa[$], qb[$], qc[$];

   always #5 clk = ~clk;

   retire_trace_buffer_if                 if_a ();
   retire_trace_buffer_if                 if_b ();
   retire_trace_buffer_if #(.SEQ_W(4))    if_c ();

   retire_trace_buffer u_a (
      .clk_i(clk), .reset_i(reset), .enable_i(en_a), .clear_i(clear_a), .wb_valid_i(wb_valid),
      .wb_pc_plus4_i(pc4), .wb_instruction_i(ir), .trace(if_a), .overflow_o(ovf_a),
      .drop_count_o(drop_a), .level_o(lvl_a)
   );
   retire_trace_buffer #(.DROP_NOPS(0)) u_b (
      .clk_i(clk), .reset_i(reset), .enable_i(en_b), .clear_i(clear_b), .wb_valid_i(wb_valid),
      .wb_pc_plus4_i(pc4), .wb_instruction_i(ir), .trace(if_b), .overflow_o(ovf_b),
      .drop_count_o(drop_b), .level_o(lvl_b)
   );
   retire_trace_buffer #(.SEQ_W(4)) u_c (
      .clk_i(clk), .reset_i(reset), .enable_i(en_c), .clear_i(clear_c), .wb_valid_i(wb_valid),
      .wb_pc_plus4_i(pc4), .wb_instruction_i(ir), .trace(if_c), .overflow_o(ovf_c),
      .drop_count_o(drop_c), .level_o(lvl_c)
   );

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ev(input logic [31:0] p, input logic [31:0] i);
      wb_valid = 1'b1;
      pc4      = p;
      ir       = i;
      tick();
      wb_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      qa.delete();
      qb.delete();
      qc.delete();
   endtask

   // Monitors: a pop happens at the next edge whenever valid & ready and no reset/clear.
   always @(negedge clk) begin
      if (!reset && !clear_a && if_a.valid && if_a.ready) begin
         if (qa.size() == 0) begin
            n_total++;
            $display("FAIL a_unexpected_rec: got seq %0d expected none", if_a.seq);
         end else chk("a_rec", {if_a.pc, if_a.ir, 32'(if_a.seq)}, qa.pop_front());
      end
   end
   always @(negedge clk) begin
      if (!reset && !clear_b && if_b.valid && if_b.ready) begin
         if (qb.size() == 0) begin
            n_total++;
            $display("FAIL b_unexpected_rec: got seq %0d expected none", if_b.seq);
         end else chk("b_rec", {if_b.pc, if_b.ir, 32'(if_b.seq)}, qb.pop_front());
      end
   end
   always @(negedge clk) begin
      if (!reset && !clear_c && if_c.valid && if_c.ready) begin
         if (qc.size() == 0) begin
            n_total++;
            $display("FAIL c_unexpected_rec: got seq %0d expected none", if_c.seq);
         end else chk("c_rec", {if_c.pc, if_c.ir, 32'(if_c.seq)}, qc.pop_front());
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   // Fill A to level 5 with overflow set, then reset or clear it.
   task automatic five(input bit use_clear);
      do_reset();
      en_a = 1'b1;
      if_a.ready = 1'b0;
      for (int i = 0; i < 17; i++) begin
         if (i < 16) qa.push_back({32'h500 + 32'(4 * i) - 32'd4, 32'h2008_1000 + 32'(i), 32'(i)});
         ev(32'h500 + 32'(4 * i), 32'h2008_1000 + 32'(i));
      end
      if_a.ready = 1'b1;
      for (int i = 0; i < 11; i++) tick();
      if_a.ready = 1'b0;
      chk("t5_level5", 96'(lvl_a), 96'd5);
      chk("t5_ovf_set", 96'(ovf_a), 96'd1);
      if (use_clear) clear_a = 1'b1;
      else reset = 1'b1;
      tick();
      clear_a = 1'b0;
      reset   = 1'b0;
      qa.delete();
      chk(use_clear ? "t5c_valid" : "t5r_valid", 96'(if_a.valid), 96'd0);
      chk(use_clear ? "t5c_level" : "t5r_level", 96'(lvl_a), 96'd0);
      chk(use_clear ? "t5c_drop"  : "t5r_drop",  96'(drop_a), 96'd0);
      chk(use_clear ? "t5c_ovf"   : "t5r_ovf",   96'(ovf_a), 96'd0);
      if_a.ready = 1'b1;
      qa.push_back({32'h2FC, 32'h2008_0005, 32'd0});
      ev(32'h300, 32'h2008_0005);
      tick();
      tick();
      chk("t5_drained", 96'(lvl_a), 96'd0);
   endtask

   initial begin
      reset = 1'b0; wb_valid = 1'b0; pc4 = '0; ir = '0;
      en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
      clear_a = 1'b0; clear_b = 1'b0; clear_c = 1'b0;
      if_a.ready = 1'b0; if_b.ready = 1'b0; if_c.ready = 1'b0;

      // 1: reset state and basic retire order
      do_reset();
      chk("rst_valid", 96'(if_a.valid), 96'd0);
      chk("rst_level", 96'(lvl_a), 96'd0);
      chk("rst_ovf",   96'(ovf_a), 96'd0);
      chk("rst_drop",  96'(drop_a), 96'd0);
      chk("rst_head",  {if_a.pc, if_a.ir, 32'(if_a.seq)}, 96'd0);
      en_a = 1'b1;
      if_a.ready = 1'b1;
      qa.push_back({32'h0, 32'h2008_0001, 32'd0});
      qa.push_back({32'h4, 32'h2008_0002, 32'd1});
      qa.push_back({32'h8, 32'h2008_0003, 32'd2});
      ev(32'h4, 32'h2008_0001);
      chk("t1_valid_latency", 96'(if_a.valid), 96'd1);
      ev(32'h8, 32'h2008_0002);
      ev(32'hC, 32'h2008_0003);
      tick(); tick();
      chk("t1_level_empty", 96'(lvl_a), 96'd0);

      // 2: overflow with reader stalled
      do_reset();
      if_a.ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (i < 16) qa.push_back({32'h100 + 32'(4 * i) - 32'd4, 32'h2008_0100 + 32'(i), 32'(i)});
         ev(32'h100 + 32'(4 * i), 32'h2008_0100 + 32'(i));
      end
      chk("t2_level", 96'(lvl_a), 96'd16);
      chk("t2_ovf",   96'(ovf_a), 96'd1);
      chk("t2_drop",  96'(drop_a), 96'd4);

      // 3: full FIFO, event plus pop on the same edge
      if_a.ready = 1'b1;
      qa.push_back({32'h1FC, 32'h2008_00AA, 32'd20});
      ev(32'h200, 32'h2008_00AA);
      chk("t3_level", 96'(lvl_a), 96'd16);
      chk("t3_drop",  96'(drop_a), 96'd4);
      for (int i = 0; i < 40 && lvl_a != 0; i++) tick();
      chk("t3_drained", 96'(lvl_a), 96'd0);
      chk("t3_ovf_sticky", 96'(ovf_a), 96'd1);

      // 4: NOP filtering on A, none on B; pc_plus4 = 0 wraps
      do_reset();
      en_b = 1'b1;
      if_a.ready = 1'b1;
      if_b.ready = 1'b1;
      qa.push_back({32'h40, 32'h8C01_0004, 32'd0});
      qa.push_back({32'h48, 32'h8C01_0004, 32'd1});
      qa.push_back({32'hFFFF_FFFC, 32'h8C01_0004, 32'd2});
      qb.push_back({32'h3C, 32'h0, 32'd0});
      qb.push_back({32'h40, 32'h8C01_0004, 32'd1});
      qb.push_back({32'h44, 32'h0, 32'd2});
      qb.push_back({32'h48, 32'h8C01_0004, 32'd3});
      qb.push_back({32'hFFFF_FFFC, 32'h0, 32'd4});
      qb.push_back({32'hFFFF_FFFC, 32'h8C01_0004, 32'd5});
      ev(32'h40, 32'h0);
      ev(32'h44, 32'h8C01_0004);
      ev(32'h48, 32'h0);
      ev(32'h4C, 32'h8C01_0004);
      ev(32'h0, 32'h0);
      ev(32'h0, 32'h8C01_0004);
      en_b = 1'b0;
      en_a = 1'b0;
      ev(32'h60, 32'h2008_0009);
      ev(32'h64, 32'h2008_0009);
      tick();
      chk("t4_disabled_level", 96'(lvl_a), 96'd0);
      en_a = 1'b1;
      qa.push_back({32'h64, 32'h2008_000A, 32'd3});
      ev(32'h68, 32'h2008_000A);
      tick(); tick();

      // 5: reset, then clear, from level 5 with overflow
      five(1'b0);
      five(1'b1);

      // 6: narrow sequence number wraps
      do_reset();
      en_a = 1'b0;
      en_c = 1'b1;
      if_c.ready = 1'b1;
      for (int i = 0; i < 18; i++) begin
         qc.push_back({32'h400 + 32'(4 * i) - 32'd4, 32'h2008_2000 + 32'(i), 32'(i % 16)});
         ev(32'h400 + 32'(4 * i), 32'h2008_2000 + 32'(i));
      end
      tick(); tick(); tick();
      chk("t6_ovf",   96'(ovf_c), 96'd0);
      chk("t6_level", 96'(lvl_c), 96'd0);

      chk("qa_empty", 96'(qa.size()), 96'd0);
      chk("qb_empty", 96'(qb.size()), 96'd0);
      chk("qc_empty", 96'(qc.size()), 96'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
